// File: rtl/morse_seg_scroller_if.sv
// Character strobes in, multiplexed seven-segment pins out,
// for the Morse decoder display path.
interface morse_seg_scroller_if #(
    parameter int DIGITS = 8
);
    logic              char_valid;
    logic [5:0]        char_code;
    logic              backspace;
    logic              clear;
    logic              blank;
    logic              blink;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] an_out;
    logic [3:0]        count;

    modport master (
        output char_valid, char_code, backspace,
        output clear, blank, blink,
        input  seg_out, an_out, count
    );

    modport slave (
        input  char_valid, char_code, backspace,
        input  clear, blank, blink,
        output seg_out, an_out, count
    );
endinterface

// File: rtl/morse_seg_scroller.sv
// Scrolling character buffer time-multiplexed onto a
// common-anode seven-segment display, with blank and blink.
module morse_seg_scroller #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64
) (
    input logic               clk,
    input logic               rst,
    morse_seg_scroller_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [5:0]        cbuf [DIGITS];
    logic [3:0]        cnt;
    logic [SW-1:0]     sdiv;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     bcnt;
    logic              bph;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] an_q;

    logic s_wrap;
    logic i_wrap;
    logic b_wrap;
    logic round_end;
    logic off;

    assign s_wrap    = (sdiv == SW'(SCAN_DIV - 1));
    assign i_wrap    = (idx == IW'(DIGITS - 1));
    assign b_wrap    = (bcnt == BW'(BLINK_DIV - 1));
    assign round_end = s_wrap && i_wrap;
    assign off       = bus.blank || (bus.blink && !bph);

    function automatic logic [7:0] glyph(input logic [5:0] c);
        case (c)
            6'h04:   glyph = 8'h08;
            6'h17:   glyph = 8'h03;
            6'h19:   glyph = 8'h46;
            6'h0B:   glyph = 8'h21;
            6'h01:   glyph = 8'h06;
            6'h11:   glyph = 8'h0E;
            6'h0D:   glyph = 8'h42;
            6'h0F:   glyph = 8'h09;
            6'h03:   glyph = 8'h70;
            6'h16:   glyph = 8'h71;
            6'h0C:   glyph = 8'h0A;
            6'h13:   glyph = 8'h47;
            6'h06:   glyph = 8'h48;
            6'h05:   glyph = 8'h2B;
            6'h0E:   glyph = 8'h23;
            6'h15:   glyph = 8'h0C;
            6'h1C:   glyph = 8'h18;
            6'h09:   glyph = 8'h4E;
            6'h07:   glyph = 8'h36;
            6'h02:   glyph = 8'h07;
            6'h08:   glyph = 8'h41;
            6'h10:   glyph = 8'h63;
            6'h0A:   glyph = 8'h01;
            6'h18:   glyph = 8'h9B;
            6'h1A:   glyph = 8'h11;
            6'h1B:   glyph = 8'h25;
            6'h23:   glyph = 8'h79;
            6'h22:   glyph = 8'h24;
            6'h21:   glyph = 8'h30;
            6'h20:   glyph = 8'h19;
            6'h1F:   glyph = 8'h12;
            6'h24:   glyph = 8'h02;
            6'h25:   glyph = 8'h58;
            6'h26:   glyph = 8'h00;
            6'h27:   glyph = 8'h10;
            6'h28:   glyph = 8'h40;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // clear beats a new character, which beats backspace
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) cbuf[i] <= '0;
            cnt <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < DIGITS; i++) cbuf[i] <= '0;
            cnt <= '0;
        end else if (bus.char_valid) begin
            for (int i = DIGITS - 1; i > 0; i--) cbuf[i] <= cbuf[i-1];
            cbuf[0] <= bus.char_code;
            if (cnt != 4'(DIGITS)) cnt <= cnt + 4'd1;
        end else if (bus.backspace && cnt != '0) begin
            for (int i = 0; i < DIGITS - 1; i++) cbuf[i] <= cbuf[i+1];
            cbuf[DIGITS-1] <= '0;
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdiv <= '0;
            idx  <= '0;
            bcnt <= '0;
            bph  <= 1'b1;
        end else begin
            sdiv <= s_wrap ? '0 : sdiv + SW'(1);
            if (s_wrap) idx <= i_wrap ? '0 : idx + IW'(1);
            if (round_end) bcnt <= b_wrap ? '0 : bcnt + BW'(1);
            // phase held on while blink is low so it resumes at once
            if (!bus.blink) bph <= 1'b1;
            else if (round_end && b_wrap) bph <= ~bph;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else if (off) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            seg_q <= glyph(cbuf[idx]);
            an_q  <= ~(DIGITS'(1) << idx);
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.an_out  = an_q;
    assign bus.count   = cnt;
endmodule

// File: tb/tb_morse_seg_scroller.sv
// Scoreboard bench: stimulus queues expected display state per
// cycle, a negedge monitor pops and compares.
module tb_morse_seg_scroller;
    logic clk;
    logic rst;
    int   k;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int         at;
        logic [7:0] seg;
        logic [3:0] an;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t sb[$];

    morse_seg_scroller_if #(.DIGITS(4)) bus ();

    morse_seg_scroller #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .BLINK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // edges seen since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else k <= k + 1;
    end

    task automatic check(input string name, input logic [7:0] seg,
                         input logic [3:0] an, input logic [3:0] cnt);
        n_tests++;
        if (bus.seg_out !== seg || bus.an_out !== an ||
            bus.count !== cnt) begin
            n_fail++;
            $display("FAIL %s @k=%0d: got seg=%h an=%b count=%0d, want seg=%h an=%b count=%0d",
                     name, k, bus.seg_out, bus.an_out, bus.count,
                     seg, an, cnt);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= k) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at < k) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: slot k=%0d missed, now k=%0d",
                         e.name, e.at, k);
            end else begin
                check(e.name, e.seg, e.an, e.cnt);
            end
        end
    end

    function automatic int dig(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic push(input int at, input logic [7:0] seg,
                        input logic [3:0] an, input logic [3:0] cnt,
                        input string name);
        exp_t e;
        e.at = at;
        e.seg = seg;
        e.an = an;
        e.cnt = cnt;
        e.name = name;
        sb.push_back(e);
    endtask

    // g holds digit3..digit0 glyphs, digit0 in the low byte
    task automatic window(input int from, input logic [31:0] g,
                          input logic [3:0] cnt, input string name);
        for (int j = 0; j < 16; j++) begin
            int d;
            d = dig(from + j);
            push(from + j, g[8*d +: 8], an_of(d), cnt, name);
        end
    endtask

    task automatic off_window(input int from, input logic [3:0] cnt,
                              input string name);
        for (int j = 0; j < 16; j++)
            push(from + j, 8'hFF, 4'b1111, cnt, name);
    endtask

    task automatic wait_k(input int target);
        while (k < target) @(negedge clk);
    endtask

    task automatic cmd(input bit cv, input logic [5:0] code,
                       input bit bs, input bit cl);
        bus.char_valid = cv;
        bus.char_code  = code;
        bus.backspace  = bs;
        bus.clear      = cl;
        @(negedge clk);
        bus.char_valid = 1'b0;
        bus.backspace  = 1'b0;
        bus.clear      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int tb0;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_code  = 6'h00;
        bus.backspace  = 1'b0;
        bus.clear      = 1'b0;
        bus.blank      = 1'b0;
        bus.blink      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 8'hFF, 4'b1111, 4'd0);

        rst = 1'b1;
        window(1, 32'hFFFFFFFF, 4'd0, "scan_empty");
        wait_k(17);

        cmd(1, 6'h04, 0, 0);
        cmd(1, 6'h17, 0, 0);
        cmd(1, 6'h19, 0, 0);
        cmd(1, 6'h0B, 0, 0);
        cmd(1, 6'h01, 0, 0);
        t = k + 1;
        window(t, {8'h03, 8'h46, 8'h21, 8'h06}, 4'd4, "fill_overflow");
        wait_k(t + 16);

        cmd(1, 6'h05, 0, 1);
        t = k + 1;
        window(t, 32'hFFFFFFFF, 4'd0, "prio_clear");
        wait_k(t + 16);
        cmd(1, 6'h23, 1, 0);
        t = k + 1;
        window(t, {8'hFF, 8'hFF, 8'hFF, 8'h79}, 4'd1, "prio_char");
        wait_k(t + 16);

        cmd(0, 6'h00, 0, 1);
        cmd(1, 6'h04, 0, 0);
        cmd(1, 6'h17, 0, 0);
        cmd(0, 6'h00, 1, 0);
        t = k + 1;
        window(t, {8'hFF, 8'hFF, 8'hFF, 8'h08}, 4'd1, "backspace");
        wait_k(t + 16);
        cmd(0, 6'h00, 1, 0);
        cmd(0, 6'h00, 1, 0);
        t = k + 1;
        window(t, 32'hFFFFFFFF, 4'd0, "bs_underflow");
        wait_k(t + 16);

        bus.blank = 1'b1;
        cmd(1, 6'h28, 0, 0);
        t = k + 1;
        off_window(t, 4'd1, "blank");
        wait_k(t + 16);
        bus.blank = 1'b0;
        t = k + 1;
        window(t, {8'hFF, 8'hFF, 8'hFF, 8'h40}, 4'd1, "unblank");
        wait_k(t + 16);

        bus.blink = 1'b1;
        tb0 = ((k + 1 + 31) / 32) * 32;
        push(tb0, dig(tb0) == 0 ? 8'h40 : 8'hFF, an_of(dig(tb0)),
             4'd1, "blink_on0");
        push(tb0 + 1, 8'hFF, 4'b1111, 4'd1, "blink_off_start");
        push(tb0 + 32, 8'hFF, 4'b1111, 4'd1, "blink_off_end");
        push(tb0 + 33, dig(tb0 + 33) == 0 ? 8'h40 : 8'hFF,
             an_of(dig(tb0 + 33)), 4'd1, "blink_on_start");
        push(tb0 + 64, dig(tb0 + 64) == 0 ? 8'h40 : 8'hFF,
             an_of(dig(tb0 + 64)), 4'd1, "blink_on_end");
        push(tb0 + 65, 8'hFF, 4'b1111, 4'd1, "blink_off2");
        wait_k(tb0 + 66);
        bus.blink = 1'b0;
        push(tb0 + 67, dig(tb0 + 67) == 0 ? 8'h40 : 8'hFF,
             an_of(dig(tb0 + 67)), 4'd1, "blink_release");
        wait_k(tb0 + 68);

        cmd(0, 6'h00, 0, 1);
        cmd(1, 6'h26, 0, 0);
        cmd(1, 6'h27, 0, 0);
        cmd(1, 6'h28, 0, 0);
        t = k + 1;
        window(t, {8'hFF, 8'h00, 8'h10, 8'h40}, 4'd3, "pre_async");
        wait_k(t + 16);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 8'hFF, 4'b1111, 4'd0);
        bus.char_valid = 1'b1;
        bus.char_code  = 6'h04;
        repeat (2) @(negedge clk);
        bus.char_valid = 1'b0;
        check("rst_strobe", 8'hFF, 4'b1111, 4'd0);
        rst = 1'b1;
        window(1, 32'hFFFFFFFF, 4'd0, "rescan");
        wait_k(17);
        @(negedge clk);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: got %0d unchecked entries, want 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
